fp_cmp_pipe: RTL

Pipelined, parameterised IEEE 754 floating-point comparison unit with valid/ready handshaking, per-operation NaN-exception policy, optional min/max result path and a saturating NaN-exception counter. It sits in the FPU result crossbar beside the add/mul pipes and accepts one operation per clock at full throughput. Its flag vector is bit-compatible with the existing combinational compare flags.

---
 rtl/fp_cmp_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_cmp_pipe.sv
//==============================================================================
// Module   : fp_cmp_pipe
// Brief    : Two-stage IEEE 754 compare / min / max unit with valid/ready
//            handshake and a saturating NaN-exception counter.
//            Optional min/max result path: define FPCMP_MINMAX_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_cmp_pipe #(
    parameter int WID  = 32,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [1:0]      op,
    input  logic [WID-1:0]  a,
    input  logic [WID-1:0]  b,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [4:0]      o,
    output logic [WID-1:0]  res,
    output logic            nanx,
    output logic [CNTW-1:0] nan_cnt,
    input  logic            cnt_clr
);

    localparam int c_EXP_W  = (WID == 32) ? 8 : (WID == 64) ? 11 : 15;
    localparam int c_FRAC_W = WID - 1 - c_EXP_W;
    localparam logic [1:0] c_OP_FCMPS = 2'b01;

    // ---------------------------------------------------------------- decode
    logic [c_EXP_W-1:0]  w_exp_a, w_exp_b;
    logic [c_FRAC_W-1:0] w_frac_a, w_frac_b;
    logic w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_zero_a, w_zero_b;
    logic w_mag_lt, w_mag_gt, w_eq_in;

    assign w_exp_a  = a[WID-2 -: c_EXP_W];
    assign w_exp_b  = b[WID-2 -: c_EXP_W];
    assign w_frac_a = a[c_FRAC_W-1:0];
    assign w_frac_b = b[c_FRAC_W-1:0];
    assign w_nan_a  = (&w_exp_a) & (|w_frac_a);
    assign w_nan_b  = (&w_exp_b) & (|w_frac_b);
    assign w_snan_a = w_nan_a & ~w_frac_a[c_FRAC_W-1];
    assign w_snan_b = w_nan_b & ~w_frac_b[c_FRAC_W-1];
    assign w_zero_a = ~|a[WID-2:0];
    assign w_zero_b = ~|b[WID-2:0];
    assign w_mag_lt = a[WID-2:0] < b[WID-2:0];
    assign w_mag_gt = b[WID-2:0] < a[WID-2:0];
    assign w_eq_in  = ~(w_nan_a | w_nan_b) & ((w_zero_a & w_zero_b) | (a == b));

    // Whole pipe advances together; a stalled output freezes both stages.
    logic w_en;
    assign w_en    = ~o_valid | o_ready;
    assign i_ready = w_en;

    // --------------------------------------------------------------- stage 1
    logic       r_s1_valid;
    logic [1:0] r_s1_op;
    logic       r_s1_nan_a, r_s1_nan_b, r_s1_snan_a, r_s1_snan_b;
    logic       r_s1_zero_a, r_s1_zero_b, r_s1_sign_a, r_s1_sign_b;
    logic       r_s1_mag_lt, r_s1_mag_gt, r_s1_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en && i_valid) begin
            r_s1_op     <= op;
            r_s1_nan_a  <= w_nan_a;
            r_s1_nan_b  <= w_nan_b;
            r_s1_snan_a <= w_snan_a;
            r_s1_snan_b <= w_snan_b;
            r_s1_zero_a <= w_zero_a;
            r_s1_zero_b <= w_zero_b;
            r_s1_sign_a <= a[WID-1];
            r_s1_sign_b <= b[WID-1];
            r_s1_mag_lt <= w_mag_lt;
            r_s1_mag_gt <= w_mag_gt;
            r_s1_eq     <= w_eq_in;
        end
    end

    // ------------------------------------------------------ stage 2 compute
    logic       w_unord, w_both_zero, w_lt, w_le, w_nanx;
    logic [4:0] w_flags;

    assign w_unord     = r_s1_nan_a | r_s1_nan_b;
    assign w_both_zero = r_s1_zero_a & r_s1_zero_b;

    always_comb begin
        w_lt = 1'b0;
        if (!w_unord && !w_both_zero) begin
            if (r_s1_sign_a != r_s1_sign_b) begin
                w_lt = r_s1_sign_a;
            end else if (r_s1_sign_a) begin
                w_lt = r_s1_mag_gt;
            end else begin
                w_lt = r_s1_mag_lt;
            end
        end
    end

    assign w_le    = w_lt | r_s1_eq;
    assign w_flags = {w_unord, r_s1_mag_lt, w_le, w_lt, r_s1_eq};
    assign w_nanx  = (r_s1_op == c_OP_FCMPS) ? w_unord : (r_s1_snan_a | r_s1_snan_b);

    // -------------------------------------------------------------- stage 2
    logic       r_o_valid;
    logic [4:0] r_flags;
    logic       r_nanx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_flags   <= 5'b0;
            r_nanx    <= 1'b0;
        end else if (w_en) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_flags <= w_flags;
                r_nanx  <= w_nanx;
            end
        end
    end

    assign o_valid = r_o_valid;
    assign o       = r_flags;
    assign nanx    = r_nanx;

`ifdef FPCMP_MINMAX_EN
    localparam logic [WID-1:0] c_QUIET_BIT = {{(WID-1){1'b0}}, 1'b1} << (c_FRAC_W - 1);

    logic [WID-1:0] r_s1_a, r_s1_b;
    logic [WID-1:0] w_res;
    logic [WID-1:0] r_res;

    always_ff @(posedge clk) begin
        if (w_en && i_valid) begin
            r_s1_a <= a;
            r_s1_b <= b;
        end
    end

    // op[0] selects max; NaNs are dropped in favour of the numeric operand.
    always_comb begin
        w_res = '0;
        if (r_s1_op[1]) begin
            if (r_s1_nan_a && r_s1_nan_b) begin
                w_res = r_s1_a | c_QUIET_BIT;
            end else if (r_s1_nan_a) begin
                w_res = r_s1_b;
            end else if (r_s1_nan_b) begin
                w_res = r_s1_a;
            end else if (w_both_zero && (r_s1_sign_a != r_s1_sign_b)) begin
                w_res = (r_s1_sign_a ^ r_s1_op[0]) ? r_s1_a : r_s1_b;
            end else begin
                w_res = (w_lt ^ r_s1_op[0]) ? r_s1_a : r_s1_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_en && r_s1_valid) begin
            r_res <= w_res;
        end
    end

    assign res = r_res;
`else
    assign res = '0;
`endif

    // ----------------------------------------------------- exception counter
    logic [CNTW-1:0] r_nan_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nan_cnt <= '0;
        end else if (cnt_clr) begin
            r_nan_cnt <= '0;
        end else if (r_o_valid && o_ready && r_nanx && (r_nan_cnt != {CNTW{1'b1}})) begin
            r_nan_cnt <= r_nan_cnt + CNTW'(1);
        end
    end

    assign nan_cnt = r_nan_cnt;

endmodule

`default_nettype wire
